// File: rtl/bitser_pkg.sv
// Shared types for the bit-serial control sequencer: opcodes, FSM states, counter width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bitser_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_LOAD  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Bit-index width; DATA_W >= 2 keeps this at least 1.
  function automatic int cnt_width(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/bitser_decode_seq_if.sv
// Command/control bundle between instruction fetch (master) and the sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: start is a strobe, accepted only while the sequencer is idle (o_busy low).
// Signals: i_instr/i_start/i_hold driven by master; o_busy/o_done and o_con_* driven by slave.
interface bitser_decode_seq_if
  import bitser_pkg::*;
#(
  parameter int DATA_W = 8
);
  localparam int CNT_W = cnt_width(DATA_W);

  logic [1:0]       i_instr;
  logic             i_start;
  logic             i_hold;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_con_mux8;
  logic             o_con_mux;
  logic             o_con_muxalu;
  logic             o_con_carry_clr;
  logic             o_con_gpr_region;
  logic             o_con_gpr_write;
  logic             o_con_gpr_shift;
  logic             o_con_mem_write;
  logic             o_con_pcincr;

  modport master (
    output i_instr, i_start, i_hold,
    input  o_busy, o_done, o_con_mux8, o_con_mux, o_con_muxalu, o_con_carry_clr,
           o_con_gpr_region, o_con_gpr_write, o_con_gpr_shift, o_con_mem_write, o_con_pcincr
  );

  modport slave (
    input  i_instr, i_start, i_hold,
    output o_busy, o_done, o_con_mux8, o_con_mux, o_con_muxalu, o_con_carry_clr,
           o_con_gpr_region, o_con_gpr_write, o_con_gpr_shift, o_con_mem_write, o_con_pcincr
  );

endinterface

// File: rtl/bitser_bit_counter.sv
// Bit index counter 0..DATA_W-1 with wrap at DATA_W-1 (not at 2^CNT_W-1).
// Latency: count updates one cycle after enable; o_last is combinational from the count.
// Backpressure: i_enable low freezes the count; i_clear has priority over i_enable.
// Ports: i_clk, i_rst (async, active-high), i_clear, i_enable, o_count, o_last.
module bitser_bit_counter
  import bitser_pkg::*;
#(
  parameter int DATA_W = 8,
  localparam int CNT_W = cnt_width(DATA_W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= (r_count == LAST_IDX) ? '0 : r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == LAST_IDX);

endmodule

// File: rtl/bitser_decode_seq.sv
// Control sequencer: steps GPR/ALU/memory controls LSB-first over DATA_W bit-cycles per opcode.
// Latency: start at edge N -> EXEC N+1..N+DATA_W, DONE N+DATA_W+1 (NOP: DONE at N+1); 1-cycle IDLE gap.
// Backpressure: i_start ignored while busy; with BITSER_HOLD_EN defined, i_hold stalls EXEC.
// Ports: i_clk, i_rst (async, active-high), io_seq (slave modport: instr/start/hold in, busy/done/con_* out).
// Build option: define BITSER_HOLD_EN to honour i_hold; otherwise i_hold is ignored.
module bitser_decode_seq
  import bitser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  bitser_decode_seq_if.slave        io_seq
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_e           r_state;
  opcode_e          r_op;
  logic             w_exec;
  logic             w_hold;
  logic             w_adv;
  logic             w_act;
  logic             w_last;
  logic [CNT_W-1:0] w_count;

  assign w_exec = (r_state == ST_EXEC);

`ifdef BITSER_HOLD_EN
  assign w_hold = io_seq.i_hold;
`else
  logic w_unused_hold;
  assign w_unused_hold = io_seq.i_hold;
  assign w_hold        = 1'b0;
`endif

  // Hold only matters in EXEC; it freezes the bit index and the state together.
  assign w_adv = w_exec && !w_hold;
  // Side-effecting controls (writes, shift, carry clear) are suppressed while held.
  assign w_act = w_adv;

  // Counter is held at zero outside EXEC so every operation starts at bit 0.
  bitser_bit_counter #(.DATA_W(DATA_W)) u_bit_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (!w_exec),
    .i_enable (w_adv),
    .o_count  (w_count),
    .o_last   (w_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_seq.i_start) begin
            r_op    <= opcode_e'(io_seq.i_instr);
            r_state <= (io_seq.i_instr == OP_NOP) ? ST_DONE : ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_adv && w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode only registered state/op/count (plus the hold gate).
  assign io_seq.o_busy           = (r_state != ST_IDLE);
  assign io_seq.o_done           = (r_state == ST_DONE);
  assign io_seq.o_con_pcincr     = (r_state == ST_DONE);
  assign io_seq.o_con_mux8       = w_exec ? w_count : '0;
  assign io_seq.o_con_mux        = w_exec && ((r_op == OP_STORE) || (r_op == OP_LOAD));
  assign io_seq.o_con_muxalu     = w_exec && (r_op == OP_ADD);
  assign io_seq.o_con_gpr_region = w_exec && (r_op == OP_STORE);
  assign io_seq.o_con_gpr_write  = w_act && ((r_op == OP_ADD) || (r_op == OP_LOAD));
  assign io_seq.o_con_gpr_shift  = w_act && (r_op != OP_NOP);
  assign io_seq.o_con_mem_write  = w_act && (r_op == OP_STORE);
  assign io_seq.o_con_carry_clr  = w_act && (r_op == OP_ADD) && (w_count == '0);

endmodule

// File: tb/tb_bitser_decode_seq.sv
// Bench for bitser_decode_seq: DATA_W=8 and DATA_W=5 instances against a per-transaction trace model.
// Latency: model queues one expected control record per cycle when a start is accepted.
// Backpressure: starts are accepted by the model only when its trace queue is empty (idle).
module tb_bitser_decode_seq;

`ifdef BITSER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pcincr;
    logic       mux;
    logic       muxalu;
    logic       carry;
    logic       region;
    logic       write;
    logic       shift;
    logic       memw;
    logic [2:0] mux8;
  } rec_t;

  logic clk;
  logic rst8;
  logic rst5;

  bitser_decode_seq_if #(.DATA_W(8)) bus8();
  bitser_decode_seq_if #(.DATA_W(5)) bus5();

  bitser_decode_seq #(.DATA_W(8)) u_dut8 (.i_clk(clk), .i_rst(rst8), .io_seq(bus8.slave));
  bitser_decode_seq #(.DATA_W(5)) u_dut5 (.i_clk(clk), .i_rst(rst5), .io_seq(bus5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pc_obs = 0;
  int   n_pc_exp = 0;
  rec_t q[$];
  rec_t last_obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t exec_rec(input logic [1:0] op, input int k);
    rec_t e;
    e      = '0;
    e.busy = 1'b1;
    e.mux8 = 3'(k);
    case (op)
      2'b01: begin e.mux = 1'b1; e.region = 1'b1; e.shift = 1'b1; e.memw = 1'b1; end
      2'b10: begin e.muxalu = 1'b1; e.write = 1'b1; e.shift = 1'b1; e.carry = (k == 0); end
      2'b11: begin e.mux = 1'b1; e.write = 1'b1; e.shift = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic rec_t done_rec();
    rec_t e;
    e        = '0;
    e.busy   = 1'b1;
    e.done   = 1'b1;
    e.pcincr = 1'b1;
    return e;
  endfunction

  function automatic rec_t read_obs(input int sel);
    rec_t o;
    if (sel == 0) begin
      o.busy = bus8.o_busy; o.done = bus8.o_done; o.pcincr = bus8.o_con_pcincr;
      o.mux = bus8.o_con_mux; o.muxalu = bus8.o_con_muxalu; o.carry = bus8.o_con_carry_clr;
      o.region = bus8.o_con_gpr_region; o.write = bus8.o_con_gpr_write;
      o.shift = bus8.o_con_gpr_shift; o.memw = bus8.o_con_mem_write; o.mux8 = bus8.o_con_mux8;
    end else begin
      o.busy = bus5.o_busy; o.done = bus5.o_done; o.pcincr = bus5.o_con_pcincr;
      o.mux = bus5.o_con_mux; o.muxalu = bus5.o_con_muxalu; o.carry = bus5.o_con_carry_clr;
      o.region = bus5.o_con_gpr_region; o.write = bus5.o_con_gpr_write;
      o.shift = bus5.o_con_gpr_shift; o.memw = bus5.o_con_mem_write; o.mux8 = bus5.o_con_mux8;
    end
    return o;
  endfunction

  task automatic drive(input int sel, input bit start, input logic [1:0] instr, input bit hold);
    bus8.i_start = (sel == 0) && start;
    bus8.i_instr = (sel == 0) ? instr : 2'b00;
    bus8.i_hold  = (sel == 0) && hold;
    bus5.i_start = (sel == 1) && start;
    bus5.i_instr = (sel == 1) ? instr : 2'b00;
    bus5.i_hold  = (sel == 1) && hold;
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance the model, step to posedge+1.
  task automatic step(input int sel, input bit start, input logic [1:0] instr, input bit hold);
    rec_t e;
    rec_t o;
    bit   idle;
    bit   held;
    int   dw;
    dw = (sel == 0) ? 8 : 5;
    drive(sel, start, instr, hold);
    @(negedge clk);
    idle = (q.size() == 0);
    e    = idle ? rec_t'('0) : q[0];
    held = !idle && HOLD_EN && hold && e.busy && !e.done;
    if (held) begin
      e.write = 1'b0; e.shift = 1'b0; e.memw = 1'b0; e.carry = 1'b0;
    end
    o = read_obs(sel);
    last_obs = o;
    check((sel == 0) ? "trace8" : "trace5", 32'(o), 32'(e));
    if (o.pcincr) n_pc_obs++;
    if (!idle && !held) begin
      if (q[0].pcincr) n_pc_exp++;
      void'(q.pop_front());
    end
    if (idle && start) begin
      if (instr != 2'b00) begin
        for (int k = 0; k < dw; k++) q.push_back(exec_rec(instr, k));
      end
      q.push_back(done_rec());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int sel);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      step(sel, 1'b0, 2'b00, 1'b0);
      guard++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    step(sel, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0t expected < 200000", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int nbusy;
    rst8 = 1'b1;
    rst5 = 1'b1;
    drive(0, 1'b0, 2'b00, 1'b0);
    #2;
    check("reset_out8", 32'(read_obs(0)), 32'd0);
    check("reset_out5", 32'(read_obs(1)), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst5 = 1'b0;
    step(0, 1'b0, 2'b00, 1'b0);

    // LOAD on DATA_W=8: bit index 0..7, then DONE, then idle.
    step(0, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1'b0, 2'b00, 1'b0);
      check("load_mux8", 32'(last_obs.mux8), 32'(i));
    end
    step(0, 1'b0, 2'b00, 1'b0);
    check("load_done", 32'(last_obs.done), 32'd1);
    step(0, 1'b0, 2'b00, 1'b0);
    check("load_busy_low", 32'(last_obs.busy), 32'd0);

    // NOP: done on the very next cycle.
    step(0, 1'b1, 2'b00, 1'b0);
    step(0, 1'b0, 2'b00, 1'b0);
    check("nop_done", 32'(last_obs.done), 32'd1);
    drain(0);

    // Start pulses while busy are ignored.
    step(0, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 9; i++) step(0, 1'b1, 2'b10, 1'b0);
    drain(0);

    // Reset mid-STORE at bit 3.
    step(0, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 2'b00, 1'b0);
    check("rst_pre_mux8", 32'(read_obs(0).mux8), 32'd3);
    rst8 = 1'b1;
    #1;
    check("rst_async", 32'(read_obs(0)), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held", 32'(read_obs(0)), 32'd0);
    rst8 = 1'b0;
    q.delete();
    step(0, 1'b0, 2'b00, 1'b0);
    step(0, 1'b1, 2'b01, 1'b0);
    drain(0);

    // Hold for two cycles at bit 7.
    step(0, 1'b1, 2'b11, 1'b0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 1'b0, 2'b00, (i == 8) || (i == 9));
      lat = i;
      if (i == 8) check("hold_write", 32'(last_obs.write), HOLD_EN ? 32'd0 : 32'd1);
      if (last_obs.done) break;
    end
    check("hold_done_lat", 32'(lat), HOLD_EN ? 32'd11 : 32'd9);
    drain(0);

    // Randomized traffic on DATA_W=8.
    for (int i = 0; i < 300; i++) begin
      step(0, $urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), $urandom_range(3, 0) == 0);
    end
    drain(0);

    // ADD on DATA_W=5: carry clear at bit 0 only, 4 wraps to 0, six busy cycles.
    step(1, 1'b1, 2'b10, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1'b0, 2'b00, 1'b0);
      if (!last_obs.busy) break;
      nbusy++;
    end
    check("add5_busy", 32'(nbusy), 32'd6);
    drain(1);

    // Randomized traffic on DATA_W=5.
    for (int i = 0; i < 300; i++) begin
      step(1, $urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), $urandom_range(3, 0) == 0);
    end
    drain(1);

    check("pcincr_count", 32'(n_pc_obs), 32'(n_pc_exp));
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
